// File: rtl/toggle_tx.sv
// toggle_tx -- source end of a toggle-handshake event crossing.
//
// Turns single-cycle strobes on pin into level flips on req_tgl, waits for
// each flip to come back on ack_tgl (synchronized locally), and queues
// strobes that arrive mid-transfer in a saturating pending counter.
//
// Optional feature macro: TOGGLE_TX_TIMEOUT_EN (adds the timeout port and
// a WAIT-state cycle counter limited by TIMEOUT_CYC).
//
// Ports:
//   ff_clk    in   clock, rising edge
//   ff_rst    in   synchronous active-high reset
//   pin       in   event strobe, one event per high cycle
//   ack_tgl   in   acknowledge toggle, asynchronous to ff_clk
//   req_tgl   out  request toggle, registered
//   busy      out  high while a transfer awaits its acknowledge
//   pend_cnt  out  events accepted but not yet launched
//   ovf       out  sticky, an event was dropped on a full counter
//   timeout   out  sticky, acknowledge not seen within TIMEOUT_CYC (macro only)
module toggle_tx #(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2,   // must be >= 2
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             ff_clk,
  input  logic             ff_rst,
  input  logic             pin,
  input  logic             ack_tgl,
  output logic             req_tgl,
  output logic             busy,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             ovf
`ifdef TOGGLE_TX_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_req;
  logic                   r_busy;
  logic [CNT_W-1:0]       r_pend;
  logic                   r_ovf;

  logic w_ack_s;
  logic w_idle;
  logic w_launch;
  logic w_dec;
  logic w_inc;

  assign w_ack_s  = r_sync[SYNC_STAGES-1];
  assign w_idle   = (r_state == S_IDLE);
  // The counter is drained before pin is allowed to launch directly, so a
  // launch from a non-empty counter always consumes a counted event.
  assign w_dec    = w_idle && (r_pend != '0);
  assign w_launch = w_idle && ((r_pend != '0) || pin);
  // pin is counted unless it is the event going out directly this cycle.
  assign w_inc    = pin && !(w_idle && (r_pend == '0));

`ifdef TOGGLE_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1) + 1;
  logic [TW-1:0] r_to_cnt;
  logic          r_timeout;
  assign timeout = r_timeout;
`endif

  always_ff @(posedge ff_clk) begin
    if (ff_rst) begin
      r_state <= S_IDLE;
      r_sync  <= '0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
`ifdef TOGGLE_TX_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ack_tgl};

      case (r_state)
        S_IDLE: begin
          // ack_s moving here is ignored; only a launch leaves IDLE.
          if (w_launch) begin
            r_req   <= ~r_req;
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
`ifdef TOGGLE_TX_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (w_ack_s == r_req) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
`ifdef TOGGLE_TX_TIMEOUT_EN
          else begin
            // Flag only; the request stays asserted and we keep waiting.
            if (r_to_cnt != TW'(TIMEOUT_CYC)) r_to_cnt <= r_to_cnt + TW'(1);
            if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) r_timeout <= 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase

      // Simultaneous increment and decrement cancel, so only the
      // pure-increment case can overflow.
      if (w_inc && !w_dec) begin
        if (&r_pend) r_ovf  <= 1'b1;
        else         r_pend <= r_pend + CNT_W'(1);
      end else if (w_dec && !w_inc) begin
        r_pend <= r_pend - CNT_W'(1);
      end
    end
  end

  assign req_tgl  = r_req;
  assign busy     = r_busy;
  assign pend_cnt = r_pend;
  assign ovf      = r_ovf;

endmodule
